// File: rtl/hub75_rx.sv
// hub75_rx: decodes HUB75 pin activity into rows held in a ping-pong buffer, replayed as a pixel stream.
// Define HUB75_RX_OE_STATS_EN to build the OE-on cycle counter reported on oe_on_cycles.
module hub75_rx #(
  parameter int MAX_COLS = 64,
  parameter int COL_W = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             h75_clk,
  input  logic             h75_lat,
  input  logic             h75_oe,
  input  logic [4:0]       h75_abcde,
  input  logic [2:0]       h75_rgb0,
  input  logic [2:0]       h75_rgb1,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [5:0]       pix_data,
  output logic [COL_W-1:0] pix_col,
  output logic [4:0]       pix_row,
  output logic [2:0]       pix_plane,
  output logic             row_done,
  output logic [COL_W-1:0] row_cols,
  output logic             overrun,
  output logic             col_ovf,
  output logic [15:0]      oe_on_cycles
);
  localparam int AW = $clog2(MAX_COLS);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t           r_state;
  logic [13:0]      r_s1, r_s2;
  logic [1:0]       r_h;
  logic             r_wbank;
  logic [COL_W-1:0] r_wcol, r_rcol;
  logic [4:0]       r_prev_row;
  logic [2:0]       r_prev_plane;
  logic [5:0]       r_mem [2][MAX_COLS];
  logic             w_shift, w_commit, w_in_range, w_last;
  logic [4:0]       w_row;
  logic [5:0]       w_px;
  logic [2:0]       w_plane;
  logic [COL_W-1:0] w_wcol_inc, w_wcol_eff, w_len, w_rnext;
  // Edges, address and data all come from the second synchronizer stage so they stay aligned.
  assign w_shift    = enable & r_s2[0] & ~r_h[0];
  assign w_commit   = enable & r_s2[1] & ~r_h[1];
  assign w_row      = r_s2[7:3];
  assign w_px       = r_s2[13:8];
  assign w_in_range = r_wcol < COL_W'(MAX_COLS);
  assign w_wcol_inc = &r_wcol ? r_wcol : r_wcol + COL_W'(1);
  assign w_wcol_eff = w_shift ? w_wcol_inc : r_wcol;
  assign w_len      = (w_wcol_eff > COL_W'(MAX_COLS)) ? COL_W'(MAX_COLS) : w_wcol_eff;
  assign w_plane    = (w_row == r_prev_row) ? r_prev_plane + 3'd1 : 3'd0;
  assign w_last     = r_rcol == row_cols - COL_W'(1);
  assign w_rnext    = pix_valid ? r_rcol + COL_W'(1) : r_rcol;
  always_ff @(posedge clk)
    if (w_shift && w_in_range) r_mem[r_wbank][r_wcol[AW-1:0]] <= w_px;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_s1         <= '0;
      r_s2         <= '0;
      r_h          <= '0;
      r_state      <= IDLE;
      r_wbank      <= 1'b0;
      r_wcol       <= '0;
      r_rcol       <= '0;
      r_prev_row   <= '0;
      r_prev_plane <= '0;
      pix_valid    <= 1'b0;
      pix_data     <= '0;
      pix_col      <= '0;
      pix_row      <= '0;
      pix_plane    <= '0;
      row_done     <= 1'b0;
      row_cols     <= '0;
      overrun      <= 1'b0;
      col_ovf      <= 1'b0;
    end else begin
      r_s1     <= {h75_rgb1, h75_rgb0, h75_abcde, h75_oe, h75_lat, h75_clk};
      r_s2     <= r_s1;
      r_h      <= r_s2[1:0];
      row_done <= 1'b0;
      if (w_shift && !w_in_range) col_ovf <= 1'b1;
      r_wcol <= w_commit ? '0 : w_wcol_eff;
      if (w_commit) begin
        r_prev_row   <= w_row;
        r_prev_plane <= w_plane;
        if (r_state == STREAM) overrun <= 1'b1;
        else begin
          pix_row   <= w_row;
          pix_plane <= w_plane;
          row_cols  <= w_len;
          if (w_len == '0) row_done <= 1'b1;
          else begin
            r_wbank <= ~r_wbank;
            r_rcol  <= '0;
            r_state <= STREAM;
          end
        end
      end
      // Output register is refilled from the read bank whenever it is empty or its beat is taken.
      if (r_state == STREAM && (!pix_valid || pix_ready)) begin
        if (pix_valid && w_last) begin
          pix_valid <= 1'b0;
          row_done  <= 1'b1;
          r_state   <= IDLE;
        end else begin
          pix_valid <= 1'b1;
          pix_data  <= r_mem[~r_wbank][w_rnext[AW-1:0]];
          pix_col   <= w_rnext;
          r_rcol    <= w_rnext;
        end
      end
    end
`ifdef HUB75_RX_OE_STATS_EN
  logic [15:0] r_oe_cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_oe_cnt     <= '0;
      oe_on_cycles <= '0;
    end else if (w_commit) begin
      oe_on_cycles <= r_oe_cnt;
      r_oe_cnt     <= '0;
    end else if (!r_s2[2] && !(&r_oe_cnt)) r_oe_cnt <= r_oe_cnt + 16'd1;
`else
  logic w_unused_oe;
  assign w_unused_oe  = r_s2[2];
  assign oe_on_cycles = '0;
`endif
endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: table-driven and randomized checks of hub75_rx against a row-level reference model.
module tb_hub75_rx;
`ifdef HUB75_RX_OE_STATS_EN
  localparam int OE_EXP = 100;
`else
  localparam int OE_EXP = 0;
`endif
  typedef struct packed {logic [8:0] col; logic [5:0] data; logic [4:0] row; logic [2:0] plane;} beat_t;
  typedef struct {logic [4:0] row; int npix; logic [2:0] exp_plane; int exp_cols; bit exp_ovf;} vec_t;

  logic clk = 0, resetn = 0, enable = 1;
  logic h75_clk = 0, h75_lat = 0, h75_oe = 1;
  logic [4:0] h75_abcde = 0;
  logic [2:0] h75_rgb0 = 0, h75_rgb1 = 0;
  logic pix_ready = 0;
  logic pix_valid, row_done, overrun, col_ovf;
  logic [5:0] pix_data;
  logic [8:0] pix_col, row_cols;
  logic [4:0] pix_row;
  logic [2:0] pix_plane;
  logic [15:0] oe_on_cycles;

  hub75_rx #(.MAX_COLS(64), .COL_W(9)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .h75_clk(h75_clk), .h75_lat(h75_lat), .h75_oe(h75_oe), .h75_abcde(h75_abcde),
    .h75_rgb0(h75_rgb0), .h75_rgb1(h75_rgb1),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_col(pix_col),
    .pix_row(pix_row), .pix_plane(pix_plane), .row_done(row_done), .row_cols(row_cols),
    .overrun(overrun), .col_ovf(col_ovf), .oe_on_cycles(oe_on_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    pix_ready = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
  end

  // Monitor: records accepted beats, row_done pulses and stall stability at the falling edge.
  beat_t got_q[$];
  int done_cnt = 0, valid_cnt = 0, stall_seen = 0, stall_bad = 0;
  bit st_prev = 0;
  beat_t st_b;
  always @(negedge clk) begin
    beat_t cur;
    cur = {pix_col, pix_data, pix_row, pix_plane};
    if (!resetn) begin
      done_cnt = 0;
      got_q.delete();
      st_prev = 0;
    end else begin
      if (st_prev) begin
        stall_seen++;
        if (!pix_valid || cur != st_b) stall_bad++;
      end
      if (pix_valid) valid_cnt++;
      if (pix_valid && pix_ready) got_q.push_back(cur);
      if (row_done) done_cnt++;
      st_prev = pix_valid && !pix_ready;
      st_b = cur;
    end
  end

  // Reference model at row granularity.
  beat_t exp_q[$];
  logic [5:0] m_pix[$];
  logic [4:0] m_prev_row = 0, m_last_row = 0;
  logic [2:0] m_prev_plane = 0, m_last_plane = 0;
  bit m_ovf = 0, m_overrun = 0;
  int m_cols = 0, m_done = 0, got_rd = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_shift(input logic [5:0] px);
    if (m_pix.size() < 64) m_pix.push_back(px);
    else m_ovf = 1;
  endtask

  task automatic model_latch(input logic [4:0] row, input bit drop);
    logic [2:0] p;
    p = (row == m_prev_row) ? 3'(m_prev_plane + 3'd1) : 3'd0;
    m_prev_row = row;
    m_prev_plane = p;
    if (drop) m_overrun = 1;
    else begin
      m_cols = m_pix.size();
      m_last_row = row;
      m_last_plane = p;
      m_done++;
      foreach (m_pix[i]) exp_q.push_back({9'(i), m_pix[i], row, p});
    end
    m_pix.delete();
  endtask

  task automatic shift_px(input logic [5:0] px);
    @(negedge clk);
    {h75_rgb1, h75_rgb0} = px;
    h75_clk = 1;
    @(negedge clk);
    @(negedge clk);
    h75_clk = 0;
    @(negedge clk);
  endtask

  task automatic latch(input logic [4:0] row);
    @(negedge clk);
    h75_abcde = row;
    h75_lat = 1;
    @(negedge clk);
    @(negedge clk);
    h75_lat = 0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && done_cnt < m_done; i++) @(posedge clk);
    chk("row_done_count", done_cnt, m_done);
  endtask

  task automatic check_beats();
    beat_t e, g;
    chk("beat_count", got_q.size() - got_rd, exp_q.size());
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front();
      g = got_q[got_rd];
      got_rd++;
      chk("beat", g, e);
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic do_row(input logic [4:0] row, input int npix, input bit rnd, input bit drop, input bit wt);
    logic [5:0] px;
    for (int i = 0; i < npix; i++) begin
      px = rnd ? 6'($urandom) : 6'(i);
      model_shift(px);
      shift_px(px);
    end
    model_latch(row, drop);
    latch(row);
    if (wt) wait_done();
  endtask

  task automatic noise();
    enable = 0;
    shift_px(6'($urandom));
    shift_px(6'($urandom));
    latch(5'($urandom));
    repeat (4) @(negedge clk);
    enable = 1;
  endtask

  vec_t tv[7];

  initial begin
    tv[0] = '{5'd5, 64, 3'd0, 64, 1'b0};
    tv[1] = '{5'd3, 8, 3'd0, 8, 1'b0};
    tv[2] = '{5'd3, 8, 3'd1, 8, 1'b0};
    tv[3] = '{5'd3, 8, 3'd2, 8, 1'b0};
    tv[4] = '{5'd3, 8, 3'd3, 8, 1'b0};
    tv[5] = '{5'd4, 8, 3'd0, 8, 1'b0};
    tv[6] = '{5'd7, 70, 3'd0, 64, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_valid", pix_valid, 0);
    chk("rst_row_done", row_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_col_ovf", col_ovf, 0);
    chk("rst_row_cols", row_cols, 0);
    chk("rst_pix_col", pix_col, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_row", pix_row, 0);
    chk("rst_pix_plane", pix_plane, 0);
    chk("rst_oe", oe_on_cycles, 0);
    resetn = 1;
    repeat (4) @(negedge clk);

    foreach (tv[k]) begin
      do_row(tv[k].row, tv[k].npix, 0, 0, 1);
      @(negedge clk);
      chk("tv_plane", pix_plane, tv[k].exp_plane);
      chk("tv_row", pix_row, tv[k].row);
      chk("tv_row_cols", row_cols, tv[k].exp_cols);
      chk("tv_col_ovf", col_ovf, tv[k].exp_ovf);
      chk("tv_beats", got_q.size() - got_rd, tv[k].exp_cols);
      check_beats();
    end

    for (int r = 0; r < 20; r++) begin
      int k, np;
      k = $urandom_range(0, 9);
      np = (k == 0) ? 0 : (k == 1) ? $urandom_range(65, 72) : $urandom_range(1, 64);
      rdy_mode = $urandom_range(1, 2);
      do_row(5'($urandom_range(0, 2)), np, 1, 0, 0);
      if ($urandom_range(0, 2) == 0) noise();
      wait_done();
      @(negedge clk);
      chk("rnd_row_cols", row_cols, m_cols);
      chk("rnd_col_ovf", col_ovf, m_ovf);
      chk("rnd_row", pix_row, m_last_row);
      chk("rnd_plane", pix_plane, m_last_plane);
      check_beats();
    end
    chk("rnd_no_overrun", overrun, 0);

    rdy_mode = 0;
    do_row(5'd9, 8, 1, 0, 0);
    for (int i = 0; i < 200 && !pix_valid; i++) @(negedge clk);
    chk("stall_valid", pix_valid, 1);
    do_row(5'd9, 4, 1, 1, 0);
    repeat (10) @(negedge clk);
    rdy_mode = 2;
    wait_done();
    @(negedge clk);
    chk("overrun", overrun, m_overrun);
    chk("stall_seen", stall_seen > 0, 1);
    chk("stall_stable", stall_bad, 0);
    check_beats();
    do_row(5'd9, 5, 1, 0, 1);
    @(negedge clk);
    chk("plane_after_drop", pix_plane, 2);
    check_beats();

    rdy_mode = 1;
    begin
      int v0;
      v0 = valid_cnt;
      do_row(5'd6, 0, 0, 0, 1);
      repeat (5) @(posedge clk);
      chk("empty_no_valid", valid_cnt - v0, 0);
    end
    @(negedge clk);
    chk("empty_row_cols", row_cols, 0);
    check_beats();

    do_row(5'd2, 30, 1, 0, 0);
    for (int i = 0; i < 500 && got_q.size() - got_rd < 5; i++) @(posedge clk);
    #3;
    chk("mid_valid", pix_valid, 1);
    resetn = 0;
    #1;
    chk("async_valid", pix_valid, 0);
    chk("async_overrun", overrun, 0);
    chk("async_col_ovf", col_ovf, 0);
    chk("async_row_cols", row_cols, 0);
    chk("async_pix_col", pix_col, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    m_pix.delete();
    got_rd = 0;
    m_prev_row = 0;
    m_prev_plane = 0;
    m_ovf = 0;
    m_overrun = 0;
    m_done = 0;
    resetn = 1;
    repeat (4) @(negedge clk);
    do_row(5'd0, 12, 1, 0, 1);
    @(negedge clk);
    chk("post_rst_plane", pix_plane, m_last_plane);
    chk("post_rst_cols", row_cols, 12);
    check_beats();

    do_row(5'd1, 3, 1, 0, 1);
    @(negedge clk);
    h75_oe = 0;
    repeat (100) @(negedge clk);
    h75_oe = 1;
    repeat (4) @(negedge clk);
    do_row(5'd1, 3, 1, 0, 1);
    @(negedge clk);
    chk("oe_on_cycles", oe_on_cycles, OE_EXP);
    check_beats();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receive-side model of the HUB75 panel interface: decodes led_clk / latch / OE / ABCDE / RGB pin activity back into pixel rows.
- Rows are captured into a ping-pong row buffer and replayed on a valid/ready stream tagged with row, plane and column.
- Sits beside the HUB75 driver in the cape fabric, fed by loopback of the P8 panel pins (GPIO_IN). Used for self-test of the driver and for bench checking.

Parameters:
- MAX_COLS, 64: row buffer depth per bank, in pixels.
- COL_W, 9: column counter width; matches the 9-bit pixels_per_row.

Ports:
- clk  in  1  fabric clock (PCLK)
- resetn  in  1  reset, asynchronous, active-low
- enable  in  1  capture enable; 0 = pin edges ignored
- h75_clk  in  1  panel shift clock; data taken on rising edge
- h75_lat  in  1  latch; rising edge commits the row
- h75_oe  in  1  output enable, active-low
- h75_abcde  in  5  row address
- h75_rgb0  in  3  {b0,g0,r0} upper-half data
- h75_rgb1  in  3  {b1,g1,r1} lower-half data
- pix_valid  out  1  stream beat valid
- pix_ready  in  1  stream beat accept
- pix_data  out  6  {rgb1,rgb0}
- pix_col  out  COL_W  shift-order index; 0 = first pixel shifted
- pix_row  out  5  latched row address
- pix_plane  out  3  bit-plane index
- row_done  out  1  1-cycle pulse after the last beat of a row
- row_cols  out  COL_W  pixel count of the last committed row
- overrun  out  1  sticky: latch seen while previous row still draining
- col_ovf  out  1  sticky: more than MAX_COLS shifts before a latch
- oe_on_cycles  out  16  see Optional Feature

Behaviour:
- Reset (asynchronous, resetn=0):
  - pix_valid, row_done, overrun, col_ovf = 0.
  - pix_* = 0, row_cols = 0, oe_on_cycles = 0.
  - Banks: write bank = 0; FSM = IDLE; column and plane counters = 0; previous row = 0.
- Input capture:
  - All h75_* inputs pass through a 2-FF synchronizer, then one history register used for edge detection.
  - An edge acts 3 clk after the pin change.
  - Data and address are taken from the same pipeline stage as the edge, so they are aligned with it.
  - Pins must hold each level for at least 2 clk.
- Shift (enable=1, rising h75_clk):
  - If wcol < MAX_COLS: write {rgb1,rgb0} at write-bank address wcol.
  - Otherwise: discard the data and set col_ovf.
  - wcol increments, saturating at 2^COL_W-1.
- Commit (enable=1, rising h75_lat):
  - Capture row = abcde.
  - Plane: if row == previous latched row, plane = prev_plane+1 (3-bit wrap); else plane = 0.
  - row_cols = min(wcol, MAX_COLS).
  - If FSM is IDLE: swap banks and go to STREAM with rcol = 0. If row_cols == 0, instead pulse row_done next cycle and stay IDLE.
  - If FSM is STREAM: no swap; set overrun; drop the row (the row/plane history still updates).
  - In both cases wcol returns to 0.
- Simultaneous clk and lat rising edges: process the shift first; the shifted pixel belongs to the committed row.
- Drain FSM:
  - IDLE -> STREAM on commit.
  - STREAM: pix_valid = 1, with pix_data = read bank[rcol] and pix_col = rcol.
  - The first beat is valid 1 clk after commit (registered buffer read).
  - On pix_valid & pix_ready: rcol++. After the beat at row_cols-1 is accepted, return to IDLE and pulse row_done for 1 clk.
  - pix_data, pix_col, pix_row and pix_plane hold stable while pix_valid & !pix_ready.
  - Throughput: 1 beat/clk when pix_ready is held high.
- enable=0:
  - Edges are ignored; counters hold.
  - A stream in progress completes normally.
  - Overrun cannot occur while disabled.
- The sticky flags clear only on reset.

Optional Feature:
- Macro: HUB75_RX_OE_STATS_EN.
- Defined:
  - A 16-bit saturating counter counts clk cycles with synchronized h75_oe == 0.
  - On each commit, oe_on_cycles loads the counter value and the counter clears. This happens even if the row is dropped for overrun.
- Undefined: no counter is built; oe_on_cycles is tied to 0.

Test Plan:
1. Shift 64 pixels with data = col[5:0], then latch with abcde = 5 -> 64 beats; pix_col 0..63, pix_data = col, pix_row = 5, pix_plane = 0; row_done once; row_cols = 64.
2. Four latches on row 3 with 8 pixels each, pix_ready always high -> planes 0,1,2,3; then a latch on row 4 -> plane 0.
3. Shift 70 pixels, then latch -> col_ovf = 1; row_cols = 64; exactly 64 beats.
4. Hold pix_ready low after commit, then shift 4 pixels and latch again -> overrun = 1; first row's 8 beats delivered intact; second row absent; beats held stable while stalled.
5. Latch with no shifts -> no pix_valid; row_done pulse; row_cols = 0. Then assert resetn=0 mid-stream -> pix_valid drops immediately (asynchronously); after reset, a clean row 0 streams correctly.
6. With HUB75_RX_OE_STATS_EN defined: hold oe low for 100 clk between latches -> oe_on_cycles = 100 at the second commit. With the macro undefined -> 0.
